adc_scan_sequencer: RTL and testbench
=====================================

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 64: max clk_i cycles spent in WAIT per channel.
REQ-002 clk_i  in  1  single system clock; all logic on its rising edge.
REQ-003 reset_i  in  1  synchronous, active-high reset.
REQ-004 syncro_i  in  1  scan trigger; rising edge starts a scan.
REQ-005 ch_mask_i  in  4  channel enable mask; bit n enables channel n.
REQ-006 adc_data_req_o  out  1  one-cycle conversion request to the shared ADC.
REQ-007 adc_ch_o  out  2  ADC channel select; valid and stable from request until WAIT exits.
REQ-008 adc_data_rdy_i  in  1  ADC data-ready; the rising edge marks valid adc_data_i.
REQ-009 adc_data_i  in  12  ADC sample, two's complement.
REQ-010 data_o  out  12  last captured sample.
REQ-011 ch_o  out  2  channel tag for data_o or for timeout_o.
REQ-012 data_rdy_o  out  1  one-cycle strobe: data_o and ch_o are valid.
REQ-013 timeout_o  out  1  one-cycle strobe: channel ch_o timed out.
REQ-014 busy_o  out  1  high while a scan is in progress (state not IDLE).
REQ-015 overrun_o  out  1  one-cycle strobe: trigger arrived while busy.

Function
REQ-016 syncro_i and adc_data_rdy_i SHALL each be registered once; an edge is current=1 and registered=0.
REQ-017 FSM states SHALL be IDLE, REQ and WAIT, with registered outputs.
REQ-018 IDLE + syncro edge + mask≠0: latch the mask, select the lowest set bit, go to REQ; busy_o high from the next cycle.
REQ-019 IDLE + syncro edge + mask=0: stay in IDLE, no request, no strobes.
REQ-020 REQ: adc_data_req_o high for exactly one cycle with adc_ch_o = selected channel; clear the timeout counter; go to WAIT.
REQ-021 WAIT + rdy edge: capture adc_data_i into data_o; ch_o = channel; data_rdy_o high in the next cycle.
REQ-022 WAIT + counter reaching TIMEOUT-1 without a rdy edge: timeout_o = 1 for one cycle; ch_o = channel; data_o unchanged.
REQ-023 After capture or timeout: clear the serviced bit in the latched mask; go to REQ for the next-lowest set bit, or to IDLE if none remain.
REQ-024 Latency: trigger edge sampled at clock k -> adc_data_req_o high in cycle k+1; rdy edge sampled at clock m -> data_rdy_o high in cycle m+1; the next request is also in cycle m+1.
REQ-025 Rdy edge and timeout in the same cycle: capture wins; no timeout_o.
REQ-026 Rdy edge outside WAIT: ignored; no data_rdy_o.
REQ-027 Syncro edge while busy: overrun_o = 1 for one cycle; the scan continues unaffected and the trigger is not queued.
REQ-028 Changes on ch_mask_i during a scan: ignored until the next scan start.
REQ-029 Every captured sample SHALL pass to data_o unmodified (no sign or width change).

Reset
REQ-030 reset_i high at a clock edge: state IDLE; latched mask and timeout counter 0; edge registers 0; data_o 12'h000, ch_o 0, adc_ch_o 0; all strobes and busy_o 0.
REQ-031 Reset mid-scan SHALL abort the scan with no further request or strobe; the first trigger after reset release is accepted normally.

Verification
REQ-032 Mask 4'b0001, syncro pulse, ADC answers 12'hE00 (-512) after 3 cycles -> one req with adc_ch_o=0; data_o=12'hE00, ch_o=0, data_rdy_o for 1 cycle; busy_o then falls.
REQ-033 Mask 4'b1010, ADC answers 312 then 157 -> req ch1 then ch3; data_o=312/ch_o=1, then data_o=157/ch_o=3; exactly two data_rdy_o strobes.
REQ-034 Mask 4'b0100, rdy never asserted, TIMEOUT=64 -> timeout_o with ch_o=2 64 cycles after entering WAIT; data_o keeps its prior value; return to IDLE.
REQ-035 Second syncro edge during WAIT of a 4-channel scan -> overrun_o pulse; all four channels still serviced in order 0..3 (e.g. -200, 700, -20, 920).
REQ-036 reset_i asserted during WAIT of ch1 (mask 4'b1111) -> outputs at reset values next cycle, no ch2 request; a new syncro pulse then scans from ch0.
REQ-037 Syncro with mask 4'b0000 -> busy_o stays 0, no adc_data_req_o; rdy pulse of 1020 while IDLE -> no data_rdy_o.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer
//
// Purpose:
//   Walks the enabled channels of a shared 4-channel ADC each time a scan
//   trigger edge arrives. Channels are serviced from lowest to highest index.
//   Each channel gets a one-cycle conversion request. The sequencer then waits
//   for the ADC data-ready edge, or for TIMEOUT cycles, before it moves on.
//
// Ports:
//   clk_i          in   1   system clock, rising edge
//   reset_i        in   1   synchronous active-high reset
//   syncro_i       in   1   scan trigger (rising edge starts a scan)
//   ch_mask_i      in   4   channel enable mask, latched at scan start
//   adc_data_req_o out  1   one-cycle conversion request
//   adc_ch_o       out  2   channel being converted
//   adc_data_rdy_i in   1   ADC data-ready (rising edge = sample valid)
//   adc_data_i     in  12   ADC sample, two's complement
//   data_o         out 12   last captured sample
//   ch_o           out  2   channel tag for data_o / timeout_o
//   data_rdy_o     out  1   one-cycle strobe, new sample on data_o
//   timeout_o      out  1   one-cycle strobe, channel ch_o timed out
//   busy_o         out  1   scan in progress
//   overrun_o      out  1   one-cycle strobe, trigger ignored while busy
// -----------------------------------------------------------------------------
module adc_scan_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        syncro_i,
  input  logic [3:0]  ch_mask_i,
  output logic        adc_data_req_o,
  output logic [1:0]  adc_ch_o,
  input  logic        adc_data_rdy_i,
  input  logic [11:0] adc_data_i,
  output logic [11:0] data_o,
  output logic [1:0]  ch_o,
  output logic        data_rdy_o,
  output logic        timeout_o,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  logic [3:0]    r_mask;
  logic [CW-1:0] r_cnt;
  logic          r_sync_d;
  logic          r_rdy_d;
  logic          r_req;
  logic [1:0]    r_adc_ch;
  logic [11:0]   r_data;
  logic [1:0]    r_ch_out;
  logic          r_data_rdy;
  logic          r_timeout;
  logic          r_busy;
  logic          r_overrun;

  state_t        w_state_nxt;
  logic [3:0]    w_mask_nxt;
  logic [3:0]    w_mask_left;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_req_nxt;
  logic [1:0]    w_adc_ch_nxt;
  logic [11:0]   w_data_nxt;
  logic [1:0]    w_ch_out_nxt;
  logic          w_data_rdy_nxt;
  logic          w_timeout_nxt;
  logic          w_overrun_nxt;
  logic          w_done;
  logic          w_sync_edge;
  logic          w_rdy_edge;

  // Priority encoder: index of the lowest set bit (mask assumed non-zero).
  function automatic logic [1:0] lowestBit(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign w_sync_edge = syncro_i & ~r_sync_d;
  assign w_rdy_edge  = adc_data_rdy_i & ~r_rdy_d;
  assign w_mask_left = r_mask & ~(4'b0001 << r_adc_ch);

  // Next-state and next-output logic. Every output is computed here and
  // registered below, so the ports never glitch. A finished channel goes
  // straight to the next request, which gives the capture-to-request latency
  // of one cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_mask_nxt     = r_mask;
    w_cnt_nxt      = r_cnt;
    w_req_nxt      = 1'b0;
    w_adc_ch_nxt   = r_adc_ch;
    w_data_nxt     = r_data;
    w_ch_out_nxt   = r_ch_out;
    w_data_rdy_nxt = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_done         = 1'b0;
    w_overrun_nxt  = w_sync_edge && (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (w_sync_edge && (ch_mask_i != 4'b0000)) begin
          w_mask_nxt   = ch_mask_i;
          w_adc_ch_nxt = lowestBit(ch_mask_i);
          w_req_nxt    = 1'b1;
          w_state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A data-ready edge takes priority over an expiring timeout.
        if (w_rdy_edge) begin
          w_data_nxt     = adc_data_i;
          w_ch_out_nxt   = r_adc_ch;
          w_data_rdy_nxt = 1'b1;
          w_done         = 1'b1;
        end else if (r_cnt == CNT_MAX) begin
          w_ch_out_nxt  = r_adc_ch;
          w_timeout_nxt = 1'b1;
          w_done        = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
        if (w_done) begin
          w_mask_nxt = w_mask_left;
          if (w_mask_left != 4'b0000) begin
            w_adc_ch_nxt = lowestBit(w_mask_left);
            w_req_nxt    = 1'b1;
            w_state_nxt  = S_REQ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers, all cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_cnt      <= '0;
      r_sync_d   <= 1'b0;
      r_rdy_d    <= 1'b0;
      r_req      <= 1'b0;
      r_adc_ch   <= '0;
      r_data     <= '0;
      r_ch_out   <= '0;
      r_data_rdy <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mask     <= w_mask_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sync_d   <= syncro_i;
      r_rdy_d    <= adc_data_rdy_i;
      r_req      <= w_req_nxt;
      r_adc_ch   <= w_adc_ch_nxt;
      r_data     <= w_data_nxt;
      r_ch_out   <= w_ch_out_nxt;
      r_data_rdy <= w_data_rdy_nxt;
      r_timeout  <= w_timeout_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_overrun  <= w_overrun_nxt;
    end
  end

  assign adc_data_req_o = r_req;
  assign adc_ch_o       = r_adc_ch;
  assign data_o         = r_data;
  assign ch_o           = r_ch_out;
  assign data_rdy_o     = r_data_rdy;
  assign timeout_o      = r_timeout;
  assign busy_o         = r_busy;
  assign overrun_o      = r_overrun;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_sequencer
//
// Purpose:
//   Self-checking bench for adc_scan_sequencer. The stimulus process acts as
//   trigger source and ADC. As it issues each action, it pushes the expected
//   request, result and overrun events into queues. Each event carries its
//   channel, its sample and the cycle in which it must appear. A negedge
//   monitor pops and compares an event whenever the DUT raises a strobe.
// -----------------------------------------------------------------------------
module tb_adc_scan_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        syncro_i;
  logic [3:0]  ch_mask_i;
  logic        adc_data_req_o;
  logic [1:0]  adc_ch_o;
  logic        adc_data_rdy_i;
  logic [11:0] adc_data_i;
  logic [11:0] data_o;
  logic [1:0]  ch_o;
  logic        data_rdy_o;
  logic        timeout_o;
  logic        busy_o;
  logic        overrun_o;

  adc_scan_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .syncro_i       (syncro_i),
    .ch_mask_i      (ch_mask_i),
    .adc_data_req_o (adc_data_req_o),
    .adc_ch_o       (adc_ch_o),
    .adc_data_rdy_i (adc_data_rdy_i),
    .adc_data_i     (adc_data_i),
    .data_o         (data_o),
    .ch_o           (ch_o),
    .data_rdy_o     (data_rdy_o),
    .timeout_o      (timeout_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Free-running count of rising edges; used to timestamp expected events.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {int kind; int ch; int data; int cyc;} ev_t;
  typedef struct {int ch; int cyc;} req_t;

  ev_t         evQ[$];
  req_t        reqQ[$];
  int          ovQ[$];
  logic [11:0] lastData;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every strobe from the DUT must match the next queued expectation.
  always @(negedge clk_i) begin
    req_t r;
    ev_t  e;
    int   k;
    int   oc;
    if (adc_data_req_o) begin
      if (reqQ.size() == 0) checkOutput("unexpected_req", 1, 0);
      else begin
        r = reqQ.pop_front();
        checkOutput("req_ch", int'(adc_ch_o), r.ch);
        checkOutput("req_cycle", cyc, r.cyc);
      end
    end
    if (data_rdy_o || timeout_o) begin
      k = data_rdy_o ? (timeout_o ? 3 : 1) : 2;
      if (evQ.size() == 0) checkOutput("unexpected_result", k, 0);
      else begin
        e = evQ.pop_front();
        checkOutput("result_kind", k, e.kind);
        checkOutput("result_ch", int'(ch_o), e.ch);
        checkOutput("result_data", int'(data_o), e.data);
        checkOutput("result_cycle", cyc, e.cyc);
      end
    end
    if (overrun_o) begin
      if (ovQ.size() == 0) checkOutput("unexpected_overrun", 1, 0);
      else begin
        oc = ovQ.pop_front();
        checkOutput("overrun_cycle", cyc, oc);
      end
    end
  end

  task automatic waitReq(output bit ok);
    int n = 0;
    while (!adc_data_req_o && n < TIMEOUT + 20) begin
      advance();
      n++;
    end
    ok = adc_data_req_o;
    if (!ok) checkOutput("req_wait_bound", 0, 1);
  endtask

  // One complete scan. dly[c] = 0 means the ADC never answers channel c.
  // Otherwise the ADC raises data-ready dly[c] cycles after the request.
  task automatic applyStimulus(input logic [3:0] mask, input bit ovr,
                               input int dly[4], input logic [11:0] dat[4]);
    int chans[$];
    bit ok;
    int rc;
    int c;
    int n;
    for (int i = 0; i < 4; i++) if (mask[i]) chans.push_back(i);
    ch_mask_i = mask;
    syncro_i  = 1'b1;
    if (chans.size() > 0) reqQ.push_back('{chans[0], cyc + 1});
    advance();
    syncro_i  = 1'b0;
    ch_mask_i = 4'($urandom_range(0, 15));
    if (chans.size() == 0) begin
      repeat (4) advance();
      checkOutput("empty_mask_busy", int'(busy_o), 0);
      return;
    end
    for (int i = 0; i < chans.size(); i++) begin
      waitReq(ok);
      if (!ok) return;
      rc = cyc;
      c  = chans[i];
      if (dly[c] == 0) begin
        evQ.push_back('{2, c, int'(lastData), rc + 1 + TIMEOUT});
        if (i + 1 < chans.size()) reqQ.push_back('{chans[i+1], rc + 1 + TIMEOUT});
        advance();
        syncro_i = ovr && (i == 0);
        if (syncro_i) ovQ.push_back(cyc + 1);
        advance();
        syncro_i = 1'b0;
      end else begin
        for (int t = 1; t <= dly[c]; t++) begin
          advance();
          syncro_i = ovr && (i == 0) && (t == 1);
          if (syncro_i) ovQ.push_back(cyc + 1);
        end
        adc_data_rdy_i = 1'b1;
        adc_data_i     = dat[c];
        evQ.push_back('{1, c, int'(dat[c]), cyc + 1});
        lastData = dat[c];
        if (i + 1 < chans.size()) reqQ.push_back('{chans[i+1], cyc + 1});
        advance();
        adc_data_rdy_i = 1'b0;
        syncro_i       = 1'b0;
        adc_data_i     = 12'($urandom);
      end
    end
    n = 0;
    while (busy_o && n < TIMEOUT + 20) begin
      advance();
      n++;
    end
    checkOutput("scan_end_busy", int'(busy_o), 0);
    advance();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          d[4];
    logic [11:0] v[4];
    bit          ok;
    reset_i        = 1'b1;
    syncro_i       = 1'b0;
    ch_mask_i      = 4'b0000;
    adc_data_rdy_i = 1'b0;
    adc_data_i     = 12'h000;
    lastData       = 12'h000;
    repeat (3) advance();
    checkOutput("reset_busy", int'(busy_o), 0);
    checkOutput("reset_req", int'(adc_data_req_o), 0);
    checkOutput("reset_data", int'(data_o), 0);
    checkOutput("reset_ch", int'(ch_o), 0);
    checkOutput("reset_adc_ch", int'(adc_ch_o), 0);
    reset_i = 1'b0;
    advance();

    $display("[TB] single channel, negative sample");
    d = '{3, 0, 0, 0}; v = '{12'hE00, 12'h0, 12'h0, 12'h0};
    applyStimulus(4'b0001, 1'b0, d, v);

    $display("[TB] channels 1 and 3");
    d = '{0, 2, 0, 4}; v = '{12'h0, 12'd312, 12'h0, 12'd157};
    applyStimulus(4'b1010, 1'b0, d, v);

    $display("[TB] channel 2 timeout");
    d = '{0, 0, 0, 0}; v = '{12'h0, 12'h0, 12'h0, 12'h0};
    applyStimulus(4'b0100, 1'b0, d, v);

    $display("[TB] four channels with overrun trigger");
    d = '{2, 5, 1, 3}; v = '{12'hF38, 12'h2BC, 12'hFEC, 12'h398};
    applyStimulus(4'b1111, 1'b1, d, v);

    $display("[TB] data-ready on the last wait cycle");
    d = '{TIMEOUT, 0, 0, 0}; v = '{12'h5A5, 12'h0, 12'h0, 12'h0};
    applyStimulus(4'b0001, 1'b0, d, v);

    $display("[TB] empty mask and stray data-ready");
    applyStimulus(4'b0000, 1'b0, d, v);
    adc_data_rdy_i = 1'b1;
    adc_data_i     = 12'd1020;
    advance();
    adc_data_rdy_i = 1'b0;
    repeat (3) advance();
    checkOutput("idle_data_kept", int'(data_o), int'(lastData));

    $display("[TB] reset during wait of channel 1");
    ch_mask_i = 4'b1111;
    syncro_i  = 1'b1;
    reqQ.push_back('{0, cyc + 1});
    advance();
    syncro_i = 1'b0;
    waitReq(ok);
    advance();
    adc_data_rdy_i = 1'b1;
    adc_data_i     = 12'h123;
    evQ.push_back('{1, 0, 32'h123, cyc + 1});
    reqQ.push_back('{1, cyc + 1});
    advance();
    adc_data_rdy_i = 1'b0;
    waitReq(ok);
    advance();
    advance();
    reset_i = 1'b1;
    advance();
    checkOutput("midreset_busy", int'(busy_o), 0);
    checkOutput("midreset_data", int'(data_o), 0);
    checkOutput("midreset_ch", int'(ch_o), 0);
    checkOutput("midreset_adc_ch", int'(adc_ch_o), 0);
    reset_i  = 1'b0;
    lastData = 12'h000;
    repeat (10) advance();
    checkOutput("post_reset_busy", int'(busy_o), 0);
    d = '{4, 2, 6, 1}; v = '{12'h7FF, 12'h800, 12'h001, 12'hFFF};
    applyStimulus(4'b1111, 1'b0, d, v);

    $display("[TB] randomized scans");
    for (int s = 0; s < 12; s++) begin
      for (int c = 0; c < 4; c++) begin
        d[c] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
        v[c] = 12'($urandom);
      end
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), d, v);
    end

    repeat (5) advance();
    checkOutput("leftover_results", evQ.size(), 0);
    checkOutput("leftover_reqs", reqQ.size(), 0);
    checkOutput("leftover_overruns", ovQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
